// File: rtl/adat_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adat_pkg: ADAT frame constants, TX state encoding, bit-position helpers    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package adat_pkg;

    localparam int ADAT_FRAME_BITS = 256;
    localparam int ADAT_SYNC_ZEROS = 10;
    localparam int ADAT_NUM_CH     = 8;
    localparam int ADAT_SAMPLE_W   = 24;
    localparam int ADAT_NIBBLES    = 48;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StSync    = 2'd1,
        StPayload = 2'd2
    } adat_tx_state_e;

    typedef struct packed {
        logic                              is_payload;
        logic                              is_sep;
        logic [$clog2(ADAT_NIBBLES)-1:0]   nibble;
        logic [1:0]                        nbit;
    } adat_pos_t;

    // Payload region starts at bit 16 as repeating groups of 4 data bits + 1 separator.
    function automatic adat_pos_t adat_bit_pos(input logic [7:0] b);
        adat_pos_t p;
        int        off;
        p   = '0;
        off = 0;
        if (b >= 8'd16) begin
            off          = int'(b) - 16;
            p.is_payload = 1'b1;
            p.nibble     = 6'(off / 5);
            p.is_sep     = ((off % 5) == 4);
            p.nbit       = 2'(off % 5);
        end
        return p;
    endfunction

    function automatic logic [7:0] adat_sample_bit(input logic [5:0] nibble,
                                                   input logic [1:0] nbit);
        int ch;
        int k;
        ch = int'(nibble) / 6;
        k  = int'(nibble) % 6;
        return 8'(ch * ADAT_SAMPLE_W + ADAT_SAMPLE_W - 1 - 4 * k - int'(nbit));
    endfunction

    function automatic logic adat_frame_bit(
        input logic [ADAT_NUM_CH*ADAT_SAMPLE_W-1:0] samples,
        input logic [3:0]                           user,
        input logic [7:0]                           b
    );
        adat_pos_t  pos;
        logic [1:0] uidx;
        logic       bit_v;
        pos   = adat_bit_pos(b);
        uidx  = 2'(8'd14 - b);
        bit_v = 1'b0;
        if (pos.is_payload) begin
            bit_v = pos.is_sep ? 1'b1 : samples[adat_sample_bit(pos.nibble, pos.nbit)];
        end else if (b == 8'(ADAT_SYNC_ZEROS) || b == 8'd15) begin
            bit_v = 1'b1;
        end else if (b > 8'(ADAT_SYNC_ZEROS)) begin
            bit_v = user[uidx];
        end
        return bit_v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/adat_frame_transmitter_nrzi_encoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nrzi_encoder: line level toggles on every ticked '1' bit                   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nrzi_encoder (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic tick_i,
    input  logic bit_i,
    output logic nrzi_o
);

    logic nrzi_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            nrzi_q <= 1'b0;
        end else if (tick_i && bit_i) begin
            nrzi_q <= ~nrzi_q;
        end
    end

    assign nrzi_o = nrzi_q;

endmodule
`default_nettype wire

// File: rtl/adat_frame_transmitter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adat_frame_transmitter: ADAT frame serialiser + NRZI line encoder          |
// | Optional: ADAT_TX_UNDERRUN_CNT_EN adds a saturating underrun counter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module adat_frame_transmitter
    import adat_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int NUM_CH  = 8
) (
    input  logic                                 clk_x4_i,
    input  logic                                 rst_ni,
    input  logic                                 enable_i,
    input  logic [ADAT_NUM_CH*ADAT_SAMPLE_W-1:0] samples_i,
    input  logic [3:0]                           user_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    output logic                                 nrzi_o,
    output logic                                 frame_start_o,
    output logic                                 underrun_o
`ifdef ADAT_TX_UNDERRUN_CNT_EN
    ,
    input  logic                                 underrun_clr_i,
    output logic [15:0]                          underrun_cnt_o
`endif
);

    localparam int         DIV_W     = $clog2(CLK_DIV);
    localparam int         SAMP_W    = ADAT_NUM_CH * ADAT_SAMPLE_W;
    localparam logic [7:0] LAST_BIT  = 8'(ADAT_FRAME_BITS - 1);
    localparam logic [7:0] SYNC_LAST = 8'(ADAT_SYNC_ZEROS);

    adat_tx_state_e    state_q, state_d;
    logic [DIV_W-1:0]  div_q;
    logic [7:0]        bit_q, bit_d;
    logic              hold_valid_q;
    logic [SAMP_W-1:0] hold_samples_q, frame_samples_q;
    logic [3:0]        hold_user_q, frame_user_q;
    logic              frame_start_q, underrun_q;
    logic              tick, emit, start, accept, line_bit;

    assign tick   = (div_q == DIV_W'(CLK_DIV - 1));
    assign accept = valid_i && !hold_valid_q;

    // The bit being emitted is the one the counter moves to on this tick.
    assign line_bit = adat_frame_bit(frame_samples_q, frame_user_q, bit_d);

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        emit    = 1'b0;
        start   = 1'b0;
        if (tick) begin
            case (state_q)
                StIdle: begin
                    if (enable_i) begin
                        state_d = StSync;
                        bit_d   = '0;
                        emit    = 1'b1;
                        start   = 1'b1;
                    end
                end
                StSync: begin
                    bit_d = bit_q + 8'd1;
                    emit  = 1'b1;
                    if (bit_q == SYNC_LAST) begin
                        state_d = StPayload;
                    end
                end
                StPayload: begin
                    if (bit_q == LAST_BIT) begin
                        bit_d = '0;
                        if (enable_i) begin
                            state_d = StSync;
                            emit    = 1'b1;
                            start   = 1'b1;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        bit_d = bit_q + 8'd1;
                        emit  = 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= StIdle;
            div_q           <= '0;
            bit_q           <= '0;
            hold_valid_q    <= 1'b0;
            hold_samples_q  <= '0;
            hold_user_q     <= '0;
            frame_samples_q <= '0;
            frame_user_q    <= '0;
            frame_start_q   <= 1'b0;
            underrun_q      <= 1'b0;
        end else begin
            div_q         <= div_q + DIV_W'(1);
            state_q       <= state_d;
            bit_q         <= bit_d;
            frame_start_q <= start;
            underrun_q    <= start && !hold_valid_q;
            if (start) begin
                frame_samples_q <= hold_valid_q ? hold_samples_q : '0;
                frame_user_q    <= hold_valid_q ? hold_user_q : '0;
            end
            // A write coinciding with the frame load lands after the old content is taken.
            if (accept) begin
                hold_samples_q <= samples_i;
                hold_user_q    <= user_i;
                hold_valid_q   <= 1'b1;
            end else if (start) begin
                hold_valid_q   <= 1'b0;
            end
        end
    end

    nrzi_encoder u_nrzi (
        .clk_i  (clk_x4_i),
        .rst_ni (rst_ni),
        .tick_i (emit),
        .bit_i  (line_bit),
        .nrzi_o (nrzi_o)
    );

    assign ready_o       = !hold_valid_q;
    assign frame_start_o = frame_start_q;
    assign underrun_o    = underrun_q;

`ifdef ADAT_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q;

    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            underrun_cnt_q <= '0;
        end else if (underrun_clr_i) begin
            underrun_cnt_q <= '0;
        end else if (underrun_q && underrun_cnt_q != 16'hFFFF) begin
            underrun_cnt_q <= underrun_cnt_q + 16'd1;
        end
    end

    assign underrun_cnt_o = underrun_cnt_q;
`endif

`ifndef SYNTHESIS
    logic [4:0] zero_run_q;

    always_ff @(posedge clk_x4_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zero_run_q <= '0;
        end else if (emit) begin
            zero_run_q <= line_bit ? 5'd0 : zero_run_q + 5'd1;
        end
    end

    always @(posedge clk_x4_i) begin
        assert (zero_run_q <= 5'(ADAT_SYNC_ZEROS))
            else $error("adat_tx: zero run longer than sync field");
        assert (NUM_CH == ADAT_NUM_CH)
            else $error("adat_tx: NUM_CH must be 8");
        assert (CLK_DIV >= 2 && CLK_DIV <= 16 && (CLK_DIV & (CLK_DIV - 1)) == 0)
            else $error("adat_tx: CLK_DIV must be a power of two in 2..16");
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adat_frame_transmitter.sv
`default_nettype none
// tb_adat_frame_transmitter: decodes the NRZI line per frame and compares it
// against an independently built frame image for directed vectors.
module tb_adat_frame_transmitter;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b0;
    logic         enable    = 1'b0;
    logic         valid     = 1'b0;
    logic [191:0] tb_samples = '0;
    logic [3:0]   tb_user   = '0;
    logic         stream_en = 1'b0;
    logic         stream_acc = 1'b0;
    int           stream_idx = 0;
    logic [191:0] samples_w;
    logic         ready, nrzi, fstart, urun;
`ifdef ADAT_TX_UNDERRUN_CNT_EN
    logic         urun_clr = 1'b0;
    logic [15:0]  urun_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    function automatic logic [191:0] pat(input int k);
        logic [191:0] s;
        s = '0;
        for (int c = 0; c < 8; c++) begin
            s[c*24 +: 24] = 24'((k + 1) * 24'h111111) ^ 24'(c * 3 + 1);
        end
        return s;
    endfunction

    assign samples_w = stream_en ? pat(stream_idx) : tb_samples;

    adat_frame_transmitter #(.CLK_DIV(4), .NUM_CH(8)) dut (
        .clk_x4_i      (clk),
        .rst_ni        (rst_n),
        .enable_i      (enable),
        .samples_i     (samples_w),
        .user_i        (tb_user),
        .valid_i       (valid),
        .ready_o       (ready),
        .nrzi_o        (nrzi),
        .frame_start_o (fstart),
        .underrun_o    (urun)
`ifdef ADAT_TX_UNDERRUN_CNT_EN
        ,
        .underrun_clr_i (urun_clr),
        .underrun_cnt_o (urun_cnt)
`endif
    );

    // Advance the streamed pattern once the DUT has taken the current one.
    always @(negedge clk) begin
        if (stream_acc) stream_idx = stream_idx + 1;
        stream_acc = stream_en && valid && ready;
    end

    function automatic logic [255:0] exp_frame(input logic [191:0] s, input logic [3:0] u);
        logic [255:0] f;
        logic [3:0]   nib;
        int           pos;
        f = '0;
        f[10] = 1'b1;
        for (int i = 0; i < 4; i++) f[11+i] = u[3-i];
        f[15] = 1'b1;
        pos = 16;
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < 6; k++) begin
                nib = s[ch*24 + 20 - 4*k +: 4];
                for (int i = 0; i < 4; i++) f[pos+i] = nib[3-i];
                f[pos+4] = 1'b1;
                pos = pos + 5;
            end
        end
        return f;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_start(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (fstart) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture(input int drop_at, output logic [255:0] bits, output logic ur,
                           output int waited, output int ready_hi, output logic ok);
        logic prev;
        bits = '0; ur = 1'b0; waited = 0; ready_hi = 0; ok = 1'b0;
        prev = nrzi;
        while (waited < 3000) begin
            @(negedge clk);
            waited++;
            if (fstart) break;
            prev = nrzi;
        end
        if (!fstart) return;
        ok       = 1'b1;
        ur       = urun;
        ready_hi = ready ? 1 : 0;
        bits[0]  = nrzi ^ prev;
        prev     = nrzi;
        for (int c = 1; c <= 1020; c++) begin
            @(negedge clk);
            if (ready) ready_hi++;
            if (urun) ur = 1'b1;
            if (c % 4 == 0) begin
                bits[c/4] = nrzi ^ prev;
                prev      = nrzi;
                if (c / 4 == drop_at) enable = 1'b0;
            end
        end
    endtask

    task automatic push(input logic [191:0] s, input logic [3:0] u);
        @(posedge clk); #1;
        tb_samples = s; tb_user = u; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    typedef struct {
        logic [191:0] samples;
        logic [3:0]   user;
        logic         exp_ready_after_push;
        logic         exp_ur;
    } vec_t;

    vec_t         vecs[4];
    logic [255:0] bits;
    logic         ur, ok;
    int           waited, ready_hi, cnt_fs, cnt_tog;
    logic [23:0]  ch0w;
    logic         nrzi_ref;

    initial begin
        vecs[0] = '{192'h0 | 192'hABCDEF, 4'hA, 1'b0, 1'b0};
        vecs[1] = '{{192{1'b1}}, 4'hF, 1'b0, 1'b0};
        vecs[2] = '{{24'h800001, 24'h7FFFFE, 24'h123456, 24'h654321,
                     24'hFEDCBA, 24'h000F00, 24'hC0FFEE, 24'h0BEEF0}, 4'h3, 1'b0, 1'b0};
        vecs[3] = '{{24'h900009, 168'h0}, 4'h0, 1'b0, 1'b0};

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_nrzi", nrzi, 1'b0);
        check("reset_ready", ready, 1'b1);
        check("reset_frame_start", fstart, 1'b0);
        check("reset_underrun", urun, 1'b0);
        rst_n = 1'b1;

        // Disabled: nothing starts
        cnt_fs = 0; cnt_tog = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (fstart) cnt_fs++;
            if (nrzi) cnt_tog++;
        end
        check("idle_no_start", cnt_fs, 0);
        check("idle_nrzi_low", cnt_tog, 0);

        // Empty frames: all-zero payload, underrun every frame, 1024-cycle period
        enable = 1'b1;
        capture(-1, bits, ur, waited, ready_hi, ok);
        check("empty1_found", ok, 1'b1);
        check("empty1_frame", bits, exp_frame('0, 4'h0));
        check("empty1_ones", $countones(bits), 50);
        check("empty1_underrun", ur, 1'b1);
        capture(-1, bits, ur, waited, ready_hi, ok);
        check("empty2_frame", bits, exp_frame('0, 4'h0));
        check("empty2_underrun", ur, 1'b1);
        check("empty2_period", waited, 4);

        // Table-driven vectors: each pushed during one frame, sent in the next
        for (int i = 0; i < 4; i++) begin
            push(vecs[i].samples, vecs[i].user);
            check($sformatf("vec%0d_ready", i), ready, vecs[i].exp_ready_after_push);
            capture(-1, bits, ur, waited, ready_hi, ok);
            check($sformatf("vec%0d_frame", i), bits, exp_frame(vecs[i].samples, vecs[i].user));
            check($sformatf("vec%0d_underrun", i), ur, vecs[i].exp_ur);
            if (i == 0) begin
                ch0w = '0;
                for (int n = 0; n < 6; n++)
                    ch0w = {ch0w[19:0], bits[16+5*n], bits[17+5*n], bits[18+5*n], bits[19+5*n]};
                check("vec0_ch0_nibbles", ch0w, 24'hABCDEF);
                check("vec0_user_bits", {bits[11], bits[12], bits[13], bits[14]}, 4'b1010);
                cnt_fs = 0;
                for (int j = 0; j < 49; j++) if (bits[15+5*j]) cnt_fs++;
                check("vec0_separators", cnt_fs, 49);
            end
        end

        // Streaming with valid held high
        @(posedge clk); #1;
        tb_user = 4'h5; valid = 1'b1; stream_en = 1'b1;
        capture(-1, bits, ur, waited, ready_hi, ok);
        check("stream_a_frame", bits, exp_frame(pat(0), 4'h5));
        check("stream_a_ready_cycles", ready_hi, 1);
        check("stream_a_underrun", ur, 1'b0);
        capture(-1, bits, ur, waited, ready_hi, ok);
        check("stream_b_frame", bits, exp_frame(pat(1), 4'h5));
        check("stream_b_ready_cycles", ready_hi, 1);
        check("stream_b_underrun", ur, 1'b0);
        valid = 1'b0; stream_en = 1'b0;

        // Drop enable at b=100: frame completes, then line goes quiet
        capture(100, bits, ur, waited, ready_hi, ok);
        check("drop_frame_complete", bits, exp_frame(pat(2), 4'h5));
        check("drop_underrun", ur, 1'b0);
        nrzi_ref = nrzi; cnt_fs = 0; cnt_tog = 0;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (fstart) cnt_fs++;
            if (nrzi !== nrzi_ref) cnt_tog++;
        end
        check("drop_no_restart", cnt_fs, 0);
        check("drop_nrzi_constant", cnt_tog, 0);

        // Reset mid-frame near b=37
        enable = 1'b1;
        wait_start(ok);
        check("rst_frame_found", ok, 1'b1);
        push(vecs[1].samples, vecs[1].user);
        check("rst_ready_before", ready, 1'b0);
        repeat (140) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_nrzi", nrzi, 1'b0);
        check("rst_mid_ready", ready, 1'b1);
        check("rst_mid_frame_start", fstart, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        capture(-1, bits, ur, waited, ready_hi, ok);
        check("rst_next_frame", bits, exp_frame('0, 4'h0));
        check("rst_next_underrun", ur, 1'b1);
        capture(-1, bits, ur, waited, ready_hi, ok);
        check("empty3_underrun", ur, 1'b1);
        capture(-1, bits, ur, waited, ready_hi, ok);
        check("empty4_underrun", ur, 1'b1);

`ifdef ADAT_TX_UNDERRUN_CNT_EN
        check("underrun_cnt_three", urun_cnt, 16'd3);
        wait_start(ok);
        check("clr_frame_found", urun, 1'b1);
        urun_clr = 1'b1;
        @(negedge clk);
        urun_clr = 1'b0;
        @(negedge clk);
        check("underrun_cnt_clear", urun_cnt, 16'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
